vending_session_ctrl: RTL and testbench

//  Parametrised, clocked vending-machine session controller; successor to the fixed 3-coin/4-item next-state calculator.

---
 rtl/vending_session_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_vending_session_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_session_ctrl.sv
// -----------------------------------------------------------------------------
// vending_session_ctrl
//
// Clocked vending-machine session controller. It holds the customer's credit,
// accepts coins, serves items the customer can afford, and hands back change
// one coin per cycle. Change is returned greedily when the customer asks for
// it or when the session has been idle for WAIT_CYCLES cycles.
//
// The controller sits between the coin/select front-end and the dispenser and
// coin hopper.
//
// Parameters
//   NUM_COINS    number of coin denominations. coin_value[i] must be nonzero
//                and strictly ascending with i.
//   NUM_ITEMS    number of selectable items
//   TOTAL_BITS   width of the credit, coin values and prices
//   WAIT_CYCLES  idle ACTIVE cycles before automatic change return (>= 1)
//
// Ports
//   clk               single clock; all state changes on the rising edge
//   reset             synchronous, active-high; overrides everything
//   i_input_coin      one bit per denomination inserted this cycle (multi-hot)
//   i_select_item     item requests this cycle (multi-hot)
//   i_trigger_return  request immediate change return (ACTIVE only)
//   coin_value        flattened static coin values, slice i = coin i
//   item_price        flattened static item prices, slice i = item i
//   o_available_item  bit i = item i affordable with the registered credit
//   o_output_item     registered one-hot dispense pulse
//   o_return_coin     registered one-hot coin-return pulse
//   o_coin_reject     registered pulse: the previous cycle's coins bounced
//   o_current_total   registered credit
//   o_busy            high while change is being returned
// -----------------------------------------------------------------------------
module vending_session_ctrl #(
  parameter int NUM_COINS   = 3,
  parameter int NUM_ITEMS   = 4,
  parameter int TOTAL_BITS  = 31,
  parameter int WAIT_CYCLES = 100
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic [NUM_ITEMS-1:0]            i_select_item,
  input  logic                            i_trigger_return,
  input  logic [NUM_COINS*TOTAL_BITS-1:0] coin_value,
  input  logic [NUM_ITEMS*TOTAL_BITS-1:0] item_price,
  output logic [NUM_ITEMS-1:0]            o_available_item,
  output logic [NUM_ITEMS-1:0]            o_output_item,
  output logic [NUM_COINS-1:0]            o_return_coin,
  output logic                            o_coin_reject,
  output logic [TOTAL_BITS-1:0]           o_current_total,
  output logic                            o_busy
);

  // The coin sum is kept NUM_COINS bits wider than the credit so that even
  // all coins at full scale plus a full credit cannot wrap before the
  // overflow comparison.
  localparam int SUM_W   = TOTAL_BITS + NUM_COINS;
  localparam int TIMER_W = $clog2(WAIT_CYCLES + 1);

  localparam logic [SUM_W-1:0]   MAX_TOTAL  = {{NUM_COINS{1'b0}}, {TOTAL_BITS{1'b1}}};
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WAIT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  // Registered state and outputs
  state_t                  state_r;
  logic [TOTAL_BITS-1:0]   total_r;
  logic [TIMER_W-1:0]      timer_r;
  logic [NUM_ITEMS-1:0]    output_item_r;
  logic [NUM_COINS-1:0]    return_coin_r;
  logic                    reject_r;
  logic                    busy_r;

  // Combinational datapath results
  logic [NUM_ITEMS-1:0]    avail_s;
  logic [SUM_W-1:0]        in_sum_s;
  logic [SUM_W-1:0]        add_total_s;
  logic                    coin_any_s;
  logic                    coin_acc_s;
  logic [TOTAL_BITS-1:0]   credit_s;
  logic [NUM_ITEMS-1:0]    req_s;
  logic [NUM_ITEMS-1:0]    serve_onehot_s;
  logic                    serve_valid_s;
  logic [TOTAL_BITS-1:0]   serve_price_s;
  logic [TOTAL_BITS-1:0]   total_after_s;
  logic [NUM_COINS-1:0]    fit_s;
  logic [NUM_COINS-1:0]    ret_onehot_s;
  logic                    ret_valid_s;
  logic [TOTAL_BITS-1:0]   ret_value_s;

  // Affordability of each item against the registered credit only
  always_comb begin
    avail_s = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      avail_s[i] = (item_price[i*TOTAL_BITS +: TOTAL_BITS] <= total_r);
    end
  end

  // Sum of inserted coins and the coin acceptance decision
  always_comb begin
    in_sum_s = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      in_sum_s = in_sum_s +
                 ({SUM_W{i_input_coin[i]}} & SUM_W'(coin_value[i*TOTAL_BITS +: TOTAL_BITS]));
    end
    add_total_s = SUM_W'(total_r) + in_sum_s;
    coin_any_s  = |i_input_coin;
    // All coins of a cycle are refused together if they would overflow.
    coin_acc_s  = coin_any_s && (add_total_s <= MAX_TOTAL);
    credit_s    = coin_acc_s ? add_total_s[TOTAL_BITS-1:0] : total_r;
  end

  // Item selection: lowest-index request that the pre-coin credit covers
  always_comb begin
    req_s          = i_select_item & avail_s;
    // Two's-complement trick isolates the lowest set request bit.
    serve_onehot_s = req_s & (~req_s + NUM_ITEMS'(1));
    serve_valid_s  = |req_s;
    serve_price_s  = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      serve_price_s = serve_price_s |
                      ({TOTAL_BITS{serve_onehot_s[i]}} & item_price[i*TOTAL_BITS +: TOTAL_BITS]);
    end
    // The price was checked against total_r <= credit_s, so no underflow.
    total_after_s = credit_s - serve_price_s;
  end

  // Change selection: largest coin not exceeding the credit
  always_comb begin
    fit_s = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      fit_s[i] = (coin_value[i*TOTAL_BITS +: TOTAL_BITS] <= total_r);
    end
    // Coin values ascend, so fit_s is a run of ones from bit 0; its top bit
    // marks the largest coin that still fits.
    ret_onehot_s = fit_s & ~(fit_s >> 1);
    ret_valid_s  = fit_s[0];
    ret_value_s  = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      ret_value_s = ret_value_s |
                    ({TOTAL_BITS{ret_onehot_s[i]}} & coin_value[i*TOTAL_BITS +: TOTAL_BITS]);
    end
  end

  // Session FSM with credit, wait timer and registered output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      total_r       <= '0;
      timer_r       <= '0;
      output_item_r <= '0;
      return_coin_r <= '0;
      reject_r      <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      output_item_r <= '0;
      return_coin_r <= '0;
      reject_r      <= 1'b0;
      case (state_r)
        ST_IDLE, ST_ACTIVE: begin
          if ((state_r == ST_ACTIVE) && i_trigger_return) begin
            // Return request wins: coins bounce, selection is ignored.
            state_r  <= ST_RETURN;
            busy_r   <= 1'b1;
            timer_r  <= '0;
            reject_r <= coin_any_s;
          end else begin
            reject_r      <= coin_any_s & ~coin_acc_s;
            output_item_r <= serve_onehot_s;
            total_r       <= total_after_s;
            if (coin_acc_s || serve_valid_s) begin
              timer_r <= TIMER_LOAD;
              if (serve_valid_s && (total_after_s == '0)) begin
                state_r <= ST_IDLE;
              end else begin
                state_r <= ST_ACTIVE;
              end
            end else if (state_r == ST_ACTIVE) begin
              // Timer holds the cycles left; the last one moves to RETURN.
              if (timer_r <= TIMER_ONE) begin
                state_r <= ST_RETURN;
                busy_r  <= 1'b1;
                timer_r <= '0;
              end else begin
                timer_r <= timer_r - TIMER_ONE;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_RETURN: begin
          reject_r <= coin_any_s;
          if (ret_valid_s) begin
            return_coin_r <= ret_onehot_s;
            total_r       <= total_r - ret_value_s;
          end else begin
            // Residual below the smallest coin is forfeited.
            total_r <= '0;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          total_r <= '0;
          timer_r <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign o_available_item = avail_s;
  assign o_output_item    = output_item_r;
  assign o_return_coin    = return_coin_r;
  assign o_coin_reject    = reject_r;
  assign o_current_total  = total_r;
  assign o_busy           = busy_r;

endmodule

// File: tb/tb_vending_session_ctrl.sv
// Self-checking bench for vending_session_ctrl: a default 31-bit instance and
// an 11-bit instance. Expected values are queued when stimulus is driven and
// compared one cycle later, after the active edge.
module tb_vending_session_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        reset_a, trig_a;
  logic [2:0]  coin_a;
  logic [3:0]  sel_a;
  logic [92:0] coin_value_a;
  logic [123:0] item_price_a;
  logic [3:0]  avail_a, out_a;
  logic [2:0]  ret_a;
  logic        reject_a, busy_a;
  logic [30:0] total_a;

  // Instance B: 11-bit credit
  logic        reset_b, trig_b;
  logic [2:0]  coin_b;
  logic [3:0]  sel_b;
  logic [32:0] coin_value_b;
  logic [43:0] item_price_b;
  logic [3:0]  avail_b, out_b;
  logic [2:0]  ret_b;
  logic        reject_b, busy_b;
  logic [10:0] total_b;

  vending_session_ctrl dut_a (
    .clk(clk), .reset(reset_a), .i_input_coin(coin_a), .i_select_item(sel_a),
    .i_trigger_return(trig_a), .coin_value(coin_value_a), .item_price(item_price_a),
    .o_available_item(avail_a), .o_output_item(out_a), .o_return_coin(ret_a),
    .o_coin_reject(reject_a), .o_current_total(total_a), .o_busy(busy_a)
  );

  vending_session_ctrl #(.TOTAL_BITS(11)) dut_b (
    .clk(clk), .reset(reset_b), .i_input_coin(coin_b), .i_select_item(sel_b),
    .i_trigger_return(trig_b), .coin_value(coin_value_b), .item_price(item_price_b),
    .o_available_item(avail_b), .o_output_item(out_b), .o_return_coin(ret_b),
    .o_coin_reject(reject_b), .o_current_total(total_b), .o_busy(busy_b)
  );

  // Signal selectors for the scoreboard
  localparam int S_TOTAL = 0, S_AVAIL = 1, S_OUT = 2, S_RET = 3, S_REJ = 4, S_BUSY = 5;
  localparam int S_B     = 10;

  int     check_cnt = 0;
  int     error_cnt = 0;
  string  tag_q[$];
  int     sig_q[$];
  longint exp_q[$];

  task automatic check_val(input string tag, input longint obs, input longint exp);
    check_cnt++;
    if (obs !== exp) begin
      error_cnt++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint observe(input int sig);
    case (sig)
      S_TOTAL:       return longint'(total_a);
      S_AVAIL:       return longint'(avail_a);
      S_OUT:         return longint'(out_a);
      S_RET:         return longint'(ret_a);
      S_REJ:         return longint'(reject_a);
      S_BUSY:        return longint'(busy_a);
      S_B + S_TOTAL: return longint'(total_b);
      S_B + S_AVAIL: return longint'(avail_b);
      S_B + S_OUT:   return longint'(out_b);
      S_B + S_RET:   return longint'(ret_b);
      S_B + S_REJ:   return longint'(reject_b);
      S_B + S_BUSY:  return longint'(busy_b);
      default:       return -64'sd1;
    endcase
  endfunction

  task automatic exp_push(input string tag, input int sig, input longint val);
    tag_q.push_back(tag);
    sig_q.push_back(sig);
    exp_q.push_back(val);
  endtask

  // Advance one clock, release pulse inputs and drain queued expectations.
  task automatic tick();
    string  t;
    int     s;
    longint v;
    @(posedge clk);
    #1;
    coin_a = 3'b000; sel_a = 4'b0000; trig_a = 1'b0;
    coin_b = 3'b000; sel_b = 4'b0000; trig_b = 1'b0;
    while (sig_q.size() > 0) begin
      t = tag_q.pop_front();
      s = sig_q.pop_front();
      v = exp_q.pop_front();
      check_val(t, observe(s), v);
    end
  endtask

  initial begin
    coin_value_a = {31'd1000, 31'd500, 31'd100};
    item_price_a = {31'd2000, 31'd1000, 31'd500, 31'd400};
    coin_value_b = {11'd1000, 11'd500, 11'd100};
    item_price_b = {11'd2000, 11'd1000, 11'd500, 11'd250};
    coin_a = 3'b000; sel_a = 4'b0000; trig_a = 1'b0;
    coin_b = 3'b000; sel_b = 4'b0000; trig_b = 1'b0;
    reset_a = 1'b1; reset_b = 1'b1;

    // Reset state
    tick();
    exp_push("rst_total", S_TOTAL, 0);   exp_push("rst_avail", S_AVAIL, 0);
    exp_push("rst_out", S_OUT, 0);       exp_push("rst_ret", S_RET, 0);
    exp_push("rst_rej", S_REJ, 0);       exp_push("rst_busy", S_BUSY, 0);
    exp_push("rst_b_total", S_B + S_TOTAL, 0);
    tick();
    reset_a = 1'b0; reset_b = 1'b0;

    // Insert 1000 then buy item1 (500)
    coin_a = 3'b100;
    exp_push("t2_total", S_TOTAL, 1000); exp_push("t2_avail", S_AVAIL, 4'b0111);
    tick();
    sel_a = 4'b0010;
    exp_push("t2_out", S_OUT, 4'b0010);  exp_push("t2_total2", S_TOTAL, 500);
    exp_push("t2_avail2", S_AVAIL, 4'b0011);
    tick();
    exp_push("t2_out_pulse", S_OUT, 0);
    tick();
    sel_a = 4'b0010;
    exp_push("buy_to_zero", S_TOTAL, 0); exp_push("buy_to_zero_out", S_OUT, 4'b0010);
    tick();

    // Same-cycle coin and select: affordability uses pre-coin credit
    coin_a = 3'b010; sel_a = 4'b0010;
    exp_push("precoin_out", S_OUT, 0);   exp_push("precoin_total", S_TOTAL, 500);
    tick();
    coin_a = 3'b001; sel_a = 4'b0001;
    exp_push("mix_out", S_OUT, 4'b0001); exp_push("mix_total", S_TOTAL, 200);
    tick();
    trig_a = 1'b1;
    exp_push("mix_busy", S_BUSY, 1);
    tick();
    exp_push("mix_ret1", S_RET, 3'b001); exp_push("mix_tot1", S_TOTAL, 100);
    tick();
    exp_push("mix_ret2", S_RET, 3'b001); exp_push("mix_tot2", S_TOTAL, 0);
    exp_push("mix_busy_last", S_BUSY, 1);
    tick();
    exp_push("mix_idle", S_BUSY, 0);     exp_push("mix_ret_end", S_RET, 0);
    tick();

    // 1600 then return; trigger beats same-cycle coin and select
    coin_a = 3'b111;
    exp_push("t3_total", S_TOTAL, 1600);
    tick();
    trig_a = 1'b1; coin_a = 3'b001; sel_a = 4'b0001;
    exp_push("t3_busy", S_BUSY, 1);      exp_push("t3_rej", S_REJ, 1);
    exp_push("t3_out", S_OUT, 0);        exp_push("t3_total_hold", S_TOTAL, 1600);
    tick();
    exp_push("t3_ret1", S_RET, 3'b100);  exp_push("t3_tot1", S_TOTAL, 600);
    tick();
    exp_push("t3_ret2", S_RET, 3'b010);  exp_push("t3_tot2", S_TOTAL, 100);
    tick();
    exp_push("t3_ret3", S_RET, 3'b001);  exp_push("t3_tot3", S_TOTAL, 0);
    exp_push("t3_busy3", S_BUSY, 1);
    tick();
    exp_push("t3_idle", S_BUSY, 0);      exp_push("t3_ret_end", S_RET, 0);
    tick();

    // Unaffordable multi-select, then multi-select at 2000
    for (int i = 0; i < 3; i++) begin
      coin_a = 3'b001;
      tick();
    end
    sel_a = 4'b1111;
    exp_push("t5_none_out", S_OUT, 0);   exp_push("t5_none_total", S_TOTAL, 300);
    tick();
    coin_a = 3'b111;
    tick();
    coin_a = 3'b001;
    exp_push("t5_total2000", S_TOTAL, 2000); exp_push("t5_avail", S_AVAIL, 4'b1111);
    tick();
    sel_a = 4'b0110;
    exp_push("t5_out", S_OUT, 4'b0010);  exp_push("t5_total", S_TOTAL, 1500);
    exp_push("t5_avail2", S_AVAIL, 4'b0111);
    tick();
    trig_a = 1'b1;
    tick();
    exp_push("t5_ret1", S_RET, 3'b100);
    tick();
    exp_push("t5_ret2", S_RET, 3'b010);  exp_push("t5_tot2", S_TOTAL, 0);
    tick();
    exp_push("t5_idle", S_BUSY, 0);
    tick();

    // Reset mid-RETURN with 700 credit
    coin_a = 3'b011;
    tick();
    coin_a = 3'b001;
    exp_push("t1_total", S_TOTAL, 700);
    tick();
    trig_a = 1'b1;
    tick();
    exp_push("t1_ret", S_RET, 3'b010);   exp_push("t1_mid", S_TOTAL, 200);
    tick();
    reset_a = 1'b1;
    coin_a = 3'b001;
    exp_push("t1_rst_total", S_TOTAL, 0); exp_push("t1_rst_busy", S_BUSY, 0);
    tick();
    tick();
    tick();
    reset_a = 1'b0;
    exp_push("t1_post_total", S_TOTAL, 0); exp_push("t1_post_busy", S_BUSY, 0);
    exp_push("t1_post_ret", S_RET, 0);     exp_push("t1_post_rej", S_REJ, 0);
    exp_push("t1_post_out", S_OUT, 0);
    tick();

    // Idle timeout: RETURN entered exactly 100 cycles after the last coin
    coin_a = 3'b100;
    exp_push("t4_total", S_TOTAL, 1000);
    tick();
    for (int k = 1; k <= 100; k++) begin
      if (k == 99) begin
        exp_push("t4_busy_99", S_BUSY, 0);
        exp_push("t4_total_99", S_TOTAL, 1000);
      end
      if (k == 100) begin
        exp_push("t4_busy_100", S_BUSY, 1);
        exp_push("t4_ret_100", S_RET, 0);
      end
      tick();
    end
    coin_a = 3'b001;
    exp_push("t4_rej", S_REJ, 1);        exp_push("t4_ret", S_RET, 3'b100);
    exp_push("t4_total_ret", S_TOTAL, 0);
    tick();
    exp_push("t4_rej_end", S_REJ, 0);    exp_push("t4_idle", S_BUSY, 0);
    tick();

    // 11-bit instance: overflow reject, then forfeit of a sub-coin residual
    coin_b = 3'b111;
    exp_push("t6_total", S_B + S_TOTAL, 1600); exp_push("t6_avail", S_B + S_AVAIL, 4'b0111);
    tick();
    for (int i = 0; i < 3; i++) begin
      coin_b = 3'b001;
      tick();
    end
    coin_b = 3'b010;
    exp_push("t6_rej", S_B + S_REJ, 1);  exp_push("t6_hold", S_B + S_TOTAL, 1900);
    tick();
    exp_push("t6_rej_end", S_B + S_REJ, 0); exp_push("t6_hold2", S_B + S_TOTAL, 1900);
    tick();
    reset_b = 1'b1;
    exp_push("t6_rst", S_B + S_TOTAL, 0);
    tick();
    reset_b = 1'b0;
    coin_b = 3'b011;
    tick();
    sel_b = 4'b0001;
    exp_push("t6_out", S_B + S_OUT, 4'b0001); exp_push("t6_350", S_B + S_TOTAL, 350);
    exp_push("t6_avail350", S_B + S_AVAIL, 4'b0001);
    tick();
    trig_b = 1'b1;
    exp_push("t6_busy", S_B + S_BUSY, 1);
    tick();
    exp_push("t6_r1", S_B + S_RET, 3'b001); exp_push("t6_t1", S_B + S_TOTAL, 250);
    tick();
    exp_push("t6_r2", S_B + S_RET, 3'b001); exp_push("t6_t2", S_B + S_TOTAL, 150);
    tick();
    exp_push("t6_r3", S_B + S_RET, 3'b001); exp_push("t6_t3", S_B + S_TOTAL, 50);
    exp_push("t6_busy_last", S_B + S_BUSY, 1);
    tick();
    exp_push("t6_forfeit", S_B + S_TOTAL, 0); exp_push("t6_idle", S_B + S_BUSY, 0);
    exp_push("t6_ret_end", S_B + S_RET, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
    $finish;
  end

endmodule
